led_pwm_bank: RTL

Multi-channel LED driver for the EPM240 designs and the generalised successor of the single-LED blink counter. CHANNELS independent outputs share one clock prescaler. Each channel is runtime-configured through a single write port. Modes: off, on, continuous blink with programmable period and duty, and a counted burst that stops on its own and reports completion.

---
 rtl/led_pwm_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM/blink/burst driver: one shared prescaler tick, one lane per output.
// Each lane holds its own mode, period, duty, phase and burst count, loaded by a single write port.

module led_pwm_lane #(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               we_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH-1:0]   period_i,
  input  logic [WIDTH-1:0]   duty_i,
  input  logic [BURST_W-1:0] count_i,
  output logic               led_o,
  output logic               busy_o
);
  localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_BURST = 2'b11;

  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   period_q, period_d, duty_q, duty_d, phase_q, phase_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d, led_q, led_d;
  logic               active;

  assign active = (mode_q == M_BLINK) || ((mode_q == M_BURST) && busy_q);

  // A write wins over the tick-driven advance on the same edge.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    if (we_i) begin
      mode_d   = mode_i;
      period_d = period_i;
      duty_d   = duty_i;
      phase_d  = '0;
      rem_d    = count_i;
      busy_d   = (mode_i == M_BURST) && (count_i != '0);
    end else if (tick_i && active) begin
      if (phase_q == period_q) begin
        phase_d = '0;
        if (busy_q) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) busy_d = 1'b0;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      M_OFF:   led_d = 1'b0;
      M_ON:    led_d = 1'b1;
      M_BLINK: led_d = (phase_q < duty_q);
      M_BURST: led_d = busy_q && (phase_q < duty_q);
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= M_OFF;
      period_q <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;
endmodule

module led_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1000,
  parameter int BURST_W  = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_duty,
  input  logic [BURST_W-1:0]  cfg_count,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy
);
  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;
  logic            tick_q;

  assign cnt_d = (cnt_q == PS_LAST) ? '0 : cnt_q + 1'b1;

  // Free-running: configuration writes never disturb the shared tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == PS_LAST);
    end
  end

  // Addresses at or beyond CHANNELS match no lane, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic we_lane;
    assign we_lane = cfg_we && (cfg_ch == CH_W'(i));

    led_pwm_lane #(.WIDTH(WIDTH), .BURST_W(BURST_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_q),
      .we_i     (we_lane),
      .mode_i   (cfg_mode),
      .period_i (cfg_period),
      .duty_i   (cfg_duty),
      .count_i  (cfg_count),
      .led_o    (led[i]),
      .busy_o   (busy[i])
    );
  end
endmodule
